// File: rtl/tcm_pkg.sv
// Shared state type, parameter defaults and address helpers for tcm_responder.
// Optional parity storage is enabled by defining TCM_PARITY_EN.
package tcm_pkg;

  localparam int unsigned TCM_IM_AW = 14;
  localparam int unsigned TCM_DM_AW = 14;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } tcm_state_e;

  // A byte address is out of range when any bit above the word index is set.
  function automatic logic dm_addr_oob(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/tcm_bank.sv
// Single-port synchronous word array: per-bit write mask, read-first registered read.
// With TCM_PARITY_EN defined, keeps one even-parity bit per word and flags bad reads.
module tcm_bank #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wmask_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o,
  output logic          par_bad_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 32; b++) begin
        if (wmask_i[b]) mem_q[addr_i][b] <= wdata_i[b];
      end
    end
  end

  // Non-blocking read of the same word being written yields the old contents.
  always_ff @(posedge clk) begin
    if (clr_i) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

`ifdef TCM_PARITY_EN
  logic             par_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic             par_bad_q;
  logic [31:0]      merged_d;

  assign merged_d = (mem_q[addr_i] & ~wmask_i) | (wdata_i & wmask_i);

  always_ff @(posedge clk) begin
    if (we_i) par_q[addr_i] <= ^merged_d;
  end

  // Words not written since reset carry no trustworthy parity.
  always_ff @(posedge clk) begin
    if (!rst_n_i) vld_q <= '0;
    else if (we_i) vld_q[addr_i] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr_i) par_bad_q <= 1'b0;
    else par_bad_q <= re_i && vld_q[addr_i] && ((^mem_q[addr_i]) != par_q[addr_i]);
  end

  assign par_bad_o = par_bad_q;
`else
  wire unused_rst = rst_n_i;
  assign par_bad_o = 1'b0;
`endif

endmodule

// File: rtl/tcm_responder.sv
// Tightly-coupled IM/DM responder: boot-load phase (LOAD) then CPU service (RUN).
// Define TCM_PARITY_EN to add per-word even parity and a sticky par_err flag.
module tcm_responder
  import tcm_pkg::*;
#(
  parameter int unsigned IM_AW = TCM_IM_AW,
  parameter int unsigned DM_AW = TCM_DM_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IM_r_addr,
  input  logic        IM_ready,
  output logic [31:0] IM_r_data,
  input  logic        DM_c_en,
  input  logic        DM_r_en,
  input  logic [31:0] DM_w_en,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_w_data,
  output logic [31:0] DM_rd_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        ld_sel,
  input  logic [15:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        mem_busy,
  output logic        dm_oob_err,
  output logic        par_err
);

  tcm_state_e state_q, state_d;
  logic       load_st, run_st;
  logic       dm_oob, dm_acc, dm_rd_req;
  logic       dm_oob_err_q;

  logic             im_we, im_re, im_clr, im_par_bad;
  logic [IM_AW-1:0] im_addr;

  logic             dm_we, dm_re, dm_clr, dm_par_bad;
  logic [DM_AW-1:0] dm_addr;
  logic [31:0]      dm_wmask, dm_wdata;

  wire unused_lsbs = ^{IM_r_addr[1:0], ld_addr[1:0]};

  assign load_st   = (state_q == LOAD);
  assign run_st    = (state_q == RUN);
  assign dm_oob    = dm_addr_oob(DM_addr, DM_AW);
  assign dm_acc    = run_st && DM_c_en;
  assign dm_rd_req = dm_acc && DM_r_en;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= LOAD;
    else state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    mem_busy = 1'b0;
    case (state_q)
      LOAD: begin
        ld_ready = 1'b1;
        mem_busy = 1'b1;
        if (ld_valid && ld_last) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = LOAD;
    endcase
  end

  // Writes are gated by rst so an aborted cycle never touches the arrays.
  assign im_we   = rst && load_st && ld_valid && !ld_sel;
  assign im_re   = rst && run_st && IM_ready;
  assign im_clr  = !rst || load_st;
  assign im_addr = load_st ? ld_addr[IM_AW+1:2] : IM_r_addr[IM_AW+1:2];

  assign dm_we    = rst && ((load_st && ld_valid && ld_sel) || (dm_acc && !dm_oob));
  assign dm_re    = rst && dm_rd_req && !dm_oob;
  assign dm_clr   = !rst || load_st || (dm_rd_req && dm_oob);
  assign dm_addr  = load_st ? ld_addr[DM_AW+1:2] : DM_addr[DM_AW+1:2];
  assign dm_wmask = load_st ? 32'hFFFF_FFFF : DM_w_en;
  assign dm_wdata = load_st ? ld_data : DM_w_data;

  tcm_bank #(.AW(IM_AW)) u_im (
    .clk       (clk),
    .rst_n_i   (rst),
    .clr_i     (im_clr),
    .re_i      (im_re),
    .we_i      (im_we),
    .addr_i    (im_addr),
    .wmask_i   (32'hFFFF_FFFF),
    .wdata_i   (ld_data),
    .rdata_o   (IM_r_data),
    .par_bad_o (im_par_bad)
  );

  tcm_bank #(.AW(DM_AW)) u_dm (
    .clk       (clk),
    .rst_n_i   (rst),
    .clr_i     (dm_clr),
    .re_i      (dm_re),
    .we_i      (dm_we),
    .addr_i    (dm_addr),
    .wmask_i   (dm_wmask),
    .wdata_i   (dm_wdata),
    .rdata_o   (DM_rd_data),
    .par_bad_o (dm_par_bad)
  );

  always_ff @(posedge clk) begin
    if (!rst) dm_oob_err_q <= 1'b0;
    else if (dm_acc && dm_oob) dm_oob_err_q <= 1'b1;
  end

  assign dm_oob_err = dm_oob_err_q;

`ifdef TCM_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (!rst) par_err_q <= 1'b0;
    else if (im_par_bad || dm_par_bad) par_err_q <= 1'b1;
  end

  assign par_err = par_err_q;
`else
  wire unused_par = im_par_bad ^ dm_par_bad;
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tcm_responder.sv
// Self-checking bench for tcm_responder: vector table, directed corners, and
// randomized traffic against an associative-array memory model.
module tb_tcm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IM_r_addr;
  logic        IM_ready;
  logic [31:0] IM_r_data;
  logic        DM_c_en, DM_r_en;
  logic [31:0] DM_w_en, DM_addr, DM_w_data, DM_rd_data;
  logic        ld_valid, ld_ready, ld_sel, ld_last;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;
  logic        mem_busy, dm_oob_err, par_err;

  always #5 clk = ~clk;

  tcm_responder dut (
    .clk(clk), .rst(rst),
    .IM_r_addr(IM_r_addr), .IM_ready(IM_ready), .IM_r_data(IM_r_data),
    .DM_c_en(DM_c_en), .DM_r_en(DM_r_en), .DM_w_en(DM_w_en), .DM_addr(DM_addr),
    .DM_w_data(DM_w_data), .DM_rd_data(DM_rd_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .mem_busy(mem_busy),
    .dm_oob_err(dm_oob_err), .par_err(par_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: word-indexed memories plus expected output registers.
  logic [31:0] im_m [int];
  logic [31:0] dm_m [int];
  logic [31:0] exp_im, exp_dm;
  logic        exp_oob, exp_par;

  typedef struct packed {
    logic        im_rdy;
    logic [15:0] im_a;
    logic        cen;
    logic        ren;
    logic [31:0] wen;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] e_im;
    logic [31:0] e_dm;
    logic        e_oob;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_cpu();
    IM_ready  = 1'b0;
    IM_r_addr = 16'h0;
    DM_c_en   = 1'b0;
    DM_r_en   = 1'b0;
    DM_w_en   = 32'h0;
    DM_addr   = 32'h0;
    DM_w_data = 32'h0;
  endtask

  task automatic junk_cpu();
    IM_ready  = 1'b1;
    IM_r_addr = 16'h0004;
    DM_c_en   = 1'b1;
    DM_r_en   = 1'b1;
    DM_w_en   = 32'hFFFF_FFFF;
    DM_addr   = 32'h0000_0014;
    DM_w_data = 32'h0BAD_0BAD;
  endtask

  // One boot-load handshake; CPU ports carry junk that must be ignored.
  task automatic ld_word(input logic sel, input int word, input logic [31:0] data, input logic last);
    junk_cpu();
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = 16'(word * 4);
    ld_data  = data;
    ld_last  = last;
    chk("ld_ready_in_load", 32'(ld_ready), 32'd1);
    chk("busy_in_load", 32'(mem_busy), 32'd1);
    if (sel) dm_m[word] = data;
    else im_m[word] = data;
    @(posedge clk); #1;
    $display("load sel=%0d word=%0d data=%h last=%0d busy=%0d", sel, word, data, last, mem_busy);
    chk("im_held_in_load", IM_r_data, 32'h0);
    chk("dm_held_in_load", DM_rd_data, 32'h0);
    chk("busy_after_hs", 32'(mem_busy), last ? 32'd0 : 32'd1);
    chk("ready_after_hs", 32'(ld_ready), last ? 32'd0 : 32'd1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    idle_cpu();
  endtask

  // One RUN-mode cycle: drive, advance the model, clock, compare.
  task automatic cpu_cycle(input logic im_rdy, input logic [15:0] im_a, input logic cen,
                           input logic ren, input logic [31:0] wen, input logic [31:0] a,
                           input logic [31:0] wd);
    int w;
    IM_ready  = im_rdy;
    IM_r_addr = im_a;
    DM_c_en   = cen;
    DM_r_en   = ren;
    DM_w_en   = wen;
    DM_addr   = a;
    DM_w_data = wd;
    if (im_rdy) exp_im = im_m[int'(im_a[15:2])];
    if (cen) begin
      if (a[31:16] != 16'h0) begin
        exp_oob = 1'b1;
        if (ren) exp_dm = 32'h0;
      end else begin
        w = int'(a[15:2]);
        if (ren) exp_dm = dm_m[w];
        dm_m[w] = (dm_m[w] & ~wen) | (wd & wen);
      end
    end
    @(posedge clk); #1;
    $display("cpu im_rdy=%0d im_a=%h cen=%0d ren=%0d wen=%h a=%h wd=%h -> im=%h dm=%h oob=%0d",
             im_rdy, im_a, cen, ren, wen, a, wd, IM_r_data, DM_rd_data, dm_oob_err);
    chk("im_r_data", IM_r_data, exp_im);
    chk("dm_rd_data", DM_rd_data, exp_dm);
    chk("dm_oob_err", 32'(dm_oob_err), 32'(exp_oob));
    chk("par_err", 32'(par_err), 32'(exp_par));
    chk("busy_in_run", 32'(mem_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = 16'h0; ld_data = 32'h0; ld_last = 1'b0;
    idle_cpu();
    exp_im = 32'h0; exp_dm = 32'h0; exp_oob = 1'b0; exp_par = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    $display("reset done busy=%0d ready=%0d", mem_busy, ld_ready);
    chk("rst_im", IM_r_data, 32'h0);
    chk("rst_dm", DM_rd_data, 32'h0);
    chk("rst_oob", 32'(dm_oob_err), 32'd0);
    chk("rst_par", 32'(par_err), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd1);
    chk("rst_busy", 32'(mem_busy), 32'd1);

    // Boot load: IM words 0..15, DM words 0..15 with word 4 last.
    ld_word(1'b0, 0, 32'h0000_0013, 1'b0);
    ld_word(1'b0, 1, 32'h0010_0093, 1'b0);
    for (int i = 2; i < 16; i++) ld_word(1'b0, i, $urandom, 1'b0);
    junk_cpu();
    @(posedge clk); #1;
    chk("gap_busy", 32'(mem_busy), 32'd1);
    chk("gap_dm_held", DM_rd_data, 32'h0);
    for (int i = 0; i < 16; i++) if (i != 4) ld_word(1'b1, i, $urandom, 1'b0);
    ld_word(1'b1, 4, 32'hDEAD_BEEF, 1'b1);

    // In RUN the loader inputs must be ignored.
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 16'h0010; ld_data = 32'hBAD0_BAD0; ld_last = 1'b1;

    cpu_cycle(1'b1, 16'h0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("first_fetch", IM_r_data, 32'h0000_0013);

    tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 32'h0000_FFFF, 32'h10, 32'h1234_5678, 32'h0000_0013, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 32'h0, 32'h10, 32'h0, 32'h0000_0013, 32'hDEAD_5678, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h10, 32'hCAFE_F00D, 32'h0000_0013, 32'hDEAD_5678, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 32'h0, 32'h10, 32'h0, 32'h0000_0013, 32'hCAFE_F00D, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'h0000_0013, 32'hCAFE_F00D, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 32'h0, 32'h13, 32'h0, 32'h0000_0013, 32'hCAFE_F00D, 1'b0};
    tbl[6]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0010_0093, 32'hCAFE_F00D, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0010_0093, 32'hCAFE_F00D, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0010_0093, 32'hCAFE_F00D, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0010_0093, 32'hCAFE_F00D, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 32'h0, 32'h0001_0000, 32'h0, 32'h0010_0093, 32'h0, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0001_0010, 32'hFFFF_FFFF, 32'h0010_0093, 32'h0, 1'b1};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 32'h0, 32'h10, 32'h0, 32'h0010_0093, 32'hCAFE_F00D, 1'b1};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0010_0093, 32'hCAFE_F00D, 1'b1};

    for (int i = 0; i < 14; i++) begin
      cpu_cycle(tbl[i].im_rdy, tbl[i].im_a, tbl[i].cen, tbl[i].ren, tbl[i].wen, tbl[i].a, tbl[i].wd);
      chk($sformatf("tbl%0d_im", i), IM_r_data, tbl[i].e_im);
      chk($sformatf("tbl%0d_dm", i), DM_rd_data, tbl[i].e_dm);
      chk($sformatf("tbl%0d_oob", i), 32'(dm_oob_err), 32'(tbl[i].e_oob));
    end

    // Randomized traffic over the loaded words, with occasional out-of-range accesses.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, wen;
      int sel;
      sel = int'($urandom_range(0, 2));
      wen = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a[31:16] = 16'($urandom_range(1, 65535));
      ld_data = $urandom;
      cpu_cycle(1'($urandom), 16'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0),
                1'($urandom), wen, a, $urandom);
    end

`ifdef TCM_PARITY_EN
    dut.u_dm.par_q[4] = ~dut.u_dm.par_q[4];
    cpu_cycle(1'b0, 16'h0, 1'b1, 1'b1, 32'h0, 32'h10, 32'h0);
    exp_par = 1'b1;
    cpu_cycle(1'b0, 16'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("par_err_set", 32'(par_err), 32'd1);
`endif

    // Mid-run reset with a write in the same cycle: write must be suppressed.
    rst = 1'b0;
    IM_ready = 1'b1; IM_r_addr = 16'h0;
    DM_c_en = 1'b1; DM_r_en = 1'b1; DM_w_en = 32'hFFFF_FFFF;
    DM_addr = 32'h14; DM_w_data = 32'h5555_5555;
    @(posedge clk); #1;
    rst = 1'b1;
    ld_valid = 1'b0; ld_last = 1'b0;
    idle_cpu();
    exp_im = 32'h0; exp_dm = 32'h0; exp_oob = 1'b0; exp_par = 1'b0;
    $display("mid-run reset busy=%0d ready=%0d oob=%0d par=%0d", mem_busy, ld_ready, dm_oob_err, par_err);
    chk("rst2_im", IM_r_data, 32'h0);
    chk("rst2_dm", DM_rd_data, 32'h0);
    chk("rst2_oob", 32'(dm_oob_err), 32'd0);
    chk("rst2_par", 32'(par_err), 32'd0);
    chk("rst2_busy", 32'(mem_busy), 32'd1);
    chk("rst2_ready", 32'(ld_ready), 32'd1);

    ld_word(1'b1, 6, 32'h6666_0006, 1'b1);
    ld_valid = 1'b0;
    cpu_cycle(1'b0, 16'h0, 1'b1, 1'b1, 32'h0, 32'h14, 32'h0);
    cpu_cycle(1'b1, 16'h0004, 1'b1, 1'b1, 32'h0, 32'h18, 32'h0);
    chk("reload_word6", DM_rd_data, 32'h6666_0006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcm_responder.md
TCM_RESPONDER -- requirements
Module: tcm_responder

Interface
REQ-001 Parameter IM_AW, default 14: instruction memory word-address width, giving 2^14 words (64 KB).
REQ-002 Parameter DM_AW, default 14: data memory word-address width, giving 2^14 words (64 KB).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 IM_r_addr  input  16  fetch byte address; the word index is IM_r_addr[IM_AW+1:2].
REQ-006 IM_ready  input  1  fetch request strobe.
REQ-007 IM_r_data  output  32  fetched instruction word, registered.
REQ-008 DM_c_en  input  1  data chip enable, active-high.
REQ-009 DM_r_en  input  1  read request, active-high.
REQ-010 DM_w_en  input  32  per-bit write mask, active-high.
REQ-011 DM_addr  input  32  data byte address.
REQ-012 DM_w_data  input  32  write data.
REQ-013 DM_rd_data  output  32  read data, registered.
REQ-014 ld_valid / ld_ready  input / output  1 / 1  boot-load handshake.
REQ-015 ld_sel  input  1  boot-load target: 0 selects IM, 1 selects DM.
REQ-016 ld_addr / ld_data / ld_last  input  16 / 32 / 1  boot-load byte address, data word, and final-word flag.
REQ-017 mem_busy  output  1  high while the boot load is in progress.
REQ-018 dm_oob_err / par_err  output  1 / 1  sticky error flags.

Function
REQ-019 FSM states are LOAD and RUN; reset enters LOAD.
REQ-020 In LOAD, ld_ready and mem_busy SHALL both be 1.
- Each cycle with ld_valid=1 writes ld_data, full word, into the array chosen by ld_sel at word ld_addr[AW+1:2].
REQ-021 In LOAD, a handshake with ld_last=1 SHALL move the FSM to RUN on the next cycle. In RUN, ld_ready=0, mem_busy=0, and ld_* inputs are ignored.
REQ-022 In LOAD, the IM and DM CPU ports SHALL be ignored: no array writes, and both output registers are held at 0.
REQ-023 In RUN, a cycle with IM_ready=1 SHALL load IM_r_data with IM[word] at the next edge (1-cycle latency). When IM_ready=0, IM_r_data holds its value.
REQ-024 In RUN, a cycle with DM_c_en=1 and DM_r_en=1 SHALL load DM_rd_data with DM[word] at the next edge. Otherwise DM_rd_data holds.
REQ-025 In RUN, a cycle with DM_c_en=1 SHALL write each bit i of DM[word] where DM_w_en[i]=1 with DM_w_data[i]. All other bits are preserved.
REQ-026 A read and a write to the same word in the same cycle SHALL be read-first: DM_rd_data returns the pre-write value.
REQ-027 With DM_c_en=0, DM_r_en and DM_w_en SHALL be ignored.
REQ-028 A DM access with DM_addr[31:DM_AW+2] != 0 is out of range and SHALL behave as follows:
- the write is dropped;
- a read returns 32'h0;
- dm_oob_err is set.
REQ-029 The low 2 bits of DM_addr and IM_r_addr SHALL be ignored; there is no misalignment fault.
REQ-030 Sticky error flags SHALL clear only on reset.

Reset
REQ-031 On a clk edge with rst=0, the block SHALL drive:
- FSM=LOAD;
- IM_r_data=0 and DM_rd_data=0;
- dm_oob_err=0 and par_err=0;
- ld_ready=1 and mem_busy=1 from the following cycle.
REQ-032 Array contents SHALL be undefined after reset and are not cleared.
REQ-033 Reset asserted mid-load or mid-run SHALL abort the current operation: the write in the reset cycle is suppressed, and the FSM restarts in LOAD.

Configuration
REQ-034 Macro TCM_PARITY_EN, when defined, SHALL add one even-parity bit per word in both arrays, updated on every write.
- Parity is recomputed over the merged word for masked writes.
- A read whose stored parity mismatches SHALL set par_err.
- Reads of never-written words are excluded from the par_err check.
REQ-035 Without TCM_PARITY_EN, no parity storage exists and par_err is tied to 0. The port list is unchanged.

Structure
REQ-036 Package tcm_pkg SHALL hold:
- the FSM state enum (LOAD, RUN);
- the parameter defaults;
- the function for out-of-range detection.
REQ-037 One sub-module, tcm_bank, SHALL be instantiated twice (IM, DM). It provides a single-port synchronous array with bit-mask write and read-first behaviour, plus optional parity.

Verification
REQ-038 Load IM word 0 = 32'h00000013 and DM word 4 = 32'hDEADBEEF (last) -> mem_busy falls 1 cycle after the last handshake. A fetch of address 0 returns 32'h00000013 one cycle later.
REQ-039 In RUN, write DM addr 0x10 with w_en=32'h0000FFFF and data=32'h12345678 over 32'hDEADBEEF -> a later read returns 32'hDEAD5678.
REQ-040 Same-cycle read+write to 0x10 with full mask and data 32'hCAFEF00D -> that read returns the old value 32'hDEAD5678. The next read returns 32'hCAFEF00D.
REQ-041 Read at DM_addr=32'h0001_0000 -> DM_rd_data=0 and dm_oob_err=1 thereafter.
REQ-042 IM_ready=0 for 3 cycles after a fetch -> IM_r_data is stable. DM_c_en=0 with w_en all-ones -> memory is unchanged.
REQ-043 With TCM_PARITY_EN defined, force a bank parity bit flip, then read that word -> par_err=1. Then assert rst=0 for one cycle -> par_err=0 and FSM=LOAD.
